// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame length and parity helpers.
// Both the transmitter and the receiver use these definitions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    localparam int MAX_DATA_BITS = 32;

    function automatic int frame_bits(input int data_bits, input int parity_bit, input int stop_bits);
        return 1 + data_bits + parity_bit + stop_bits;
    endfunction

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [MAX_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, MSB-first data, optional even parity, stop bits.
// Each bit lasts one Clk cycle. Break frames hold the line low for one frame length.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_BIT = 1,
    parameter int STOP_BITS  = 2
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Transmit_Start,
    input  logic                 Send_Break,
    input  logic                 CTS,
    output logic                 Tx,
    output logic                 Tx_Busy,
    output logic                 Tx_Done
);

    localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_BIT, STOP_BITS);
    localparam int CW         = $clog2(FRAME_BITS + 1);
    localparam int SHW        = DATA_BITS + PARITY_BIT;

    typedef logic [CW-1:0] cnt_t;

    uart_state_e            state_q, state_d;
    cnt_t                   cnt_q, cnt_d;
    logic [SHW-1:0]         shreg_q, shreg_d;
    logic                   tx_q, tx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [MAX_DATA_BITS-1:0] data_ext;
    logic [DATA_BITS:0]       load_v;

    // The parity bit rides in the shift register below the data, so the
    // parity cycle simply shifts out one more bit.
    always_comb begin
        data_ext                = '0;
        data_ext[DATA_BITS-1:0] = Tx_Data;
        load_v                  = {Tx_Data, even_parity(data_ext)};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (Send_Break) begin
                    state_d = BREAK;
                    tx_d    = 1'b0;
                    cnt_d   = cnt_t'(FRAME_BITS - 1);
                end else if (Transmit_Start && CTS) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    shreg_d = load_v[DATA_BITS -: SHW];
                end
            end
            START: begin
                state_d = DATA;
                tx_d    = shreg_q[SHW-1];
                shreg_d = shreg_q << 1;
                cnt_d   = cnt_t'(DATA_BITS - 1);
            end
            DATA: begin
                if (cnt_q != '0) begin
                    cnt_d   = cnt_q - cnt_t'(1);
                    tx_d    = shreg_q[SHW-1];
                    shreg_d = shreg_q << 1;
                end else if (PARITY_BIT != 0) begin
                    state_d = PARITY;
                    tx_d    = shreg_q[SHW-1];
                    shreg_d = shreg_q << 1;
                end else begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    cnt_d   = cnt_t'(STOP_BITS - 1);
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = 1'b1;
                cnt_d   = cnt_t'(STOP_BITS - 1);
            end
            STOP: begin
                tx_d = 1'b1;
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - cnt_t'(1);
            end
            BREAK: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                    tx_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
        // Last cycle of a frame or break is the one entered with the counter exhausted.
        done_d = ((state_d == STOP) || (state_d == BREAK)) && (cnt_d == '0);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Tx      = tx_q;
    assign Tx_Busy = busy_q;
    assign Tx_Done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-level model pushes expected per-cycle line states
// into a queue; a negedge monitor pops and compares them against the DUT.
module tb_uart_tx;

    localparam int DB = 8;
    localparam int PB = 1;
    localparam int SB = 2;
    localparam int FB = 1 + DB + PB + SB;

    logic          Clk;
    logic          Rst;
    logic [DB-1:0] Tx_Data;
    logic          Transmit_Start;
    logic          Send_Break;
    logic          CTS;
    logic          Tx;
    logic          Tx_Busy;
    logic          Tx_Done;

    int tests = 0;
    int fails = 0;

    // Each entry is {tx, busy, done} for one cycle.
    logic [2:0] exp_q[$];
    logic [2:0] mon_exp;
    logic [2:0] mon_act;

    uart_tx #(.DATA_BITS(DB), .PARITY_BIT(PB), .STOP_BITS(SB)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Tx_Data        (Tx_Data),
        .Transmit_Start (Transmit_Start),
        .Send_Break     (Send_Break),
        .CTS            (CTS),
        .Tx             (Tx),
        .Tx_Busy        (Tx_Busy),
        .Tx_Done        (Tx_Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic push_frame(input logic [DB-1:0] d);
        exp_q.push_back(3'b010);
        for (int i = DB - 1; i >= 0; i--) exp_q.push_back({d[i], 1'b1, 1'b0});
        exp_q.push_back({^d, 1'b1, 1'b0});
        for (int i = 0; i < SB; i++) exp_q.push_back({1'b1, 1'b1, (i == SB - 1)});
        exp_q.push_back(3'b100);
    endtask

    task automatic push_break();
        for (int i = 0; i < FB; i++) exp_q.push_back({1'b0, 1'b1, (i == FB - 1)});
        exp_q.push_back(3'b100);
    endtask

    // Model: a new frame may begin only once the line has been idle for a cycle,
    // which is exactly when the expectation queue has drained.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            if (Send_Break)                push_break();
            else if (Transmit_Start && CTS) push_frame(Tx_Data);
        end
    end

    always @(negedge Clk) begin
        mon_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b100;
        mon_act = {Tx, Tx_Busy, Tx_Done};
        tests++;
        if (mon_act !== mon_exp) begin
            fails++;
            $display("FAIL line @%0t: got tx/busy/done=%b expected %b", $time, mon_act, mon_exp);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic capture(input int n, output logic [31:0] tv, output logic [31:0] bv,
                           output logic [31:0] dv);
        tv = '0;
        bv = '0;
        dv = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            tv = {tv[30:0], Tx};
            bv = {bv[30:0], Tx_Busy};
            dv = {dv[30:0], Tx_Done};
        end
    endtask

    task automatic idle(input int n);
        Transmit_Start = 1'b0;
        Send_Break     = 1'b0;
        repeat (n) @(negedge Clk);
    endtask

    logic [31:0] tv, bv, dv, tv2, bv2, dv2;
    int          k;

    initial begin
        Rst            = 1'b1;
        Tx_Data        = '0;
        Transmit_Start = 1'b0;
        Send_Break     = 1'b0;
        CTS            = 1'b1;
        repeat (3) @(negedge Clk);
        check("reset_state", {29'd0, Tx, Tx_Busy, Tx_Done}, 32'b100);
        #2 Rst = 1'b0;

        // 0xA5 frame: exact bit order, busy length and done position
        @(negedge Clk);
        Tx_Data = 8'hA5;
        Transmit_Start = 1'b1;
        capture(12, tv, bv, dv);
        Transmit_Start = 1'b0;
        check("a5_bits", tv, 32'b0101_0010_1011);
        check("a5_busy", bv, 32'hFFF);
        check("a5_done", dv, 32'b0000_0000_0001);
        idle(3);

        // 0x01: odd data, parity bit is 1
        @(negedge Clk);
        Tx_Data = 8'h01;
        Transmit_Start = 1'b1;
        capture(12, tv, bv, dv);
        Transmit_Start = 1'b0;
        check("x01_bits", tv, 32'b0000_0000_1111);
        idle(3);

        // CTS low holds off a pending request
        @(negedge Clk);
        CTS = 1'b0;
        Tx_Data = 8'h5A;
        Transmit_Start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            check("cts_hold", {30'd0, Tx, Tx_Busy}, 32'b10);
        end
        CTS = 1'b1;
        @(negedge Clk);
        check("cts_release_start", {30'd0, Tx, Tx_Busy}, 32'b01);
        Transmit_Start = 1'b0;
        idle(14);

        // Break wins over a simultaneous data request, which stays pending
        @(negedge Clk);
        Tx_Data = 8'h3C;
        Send_Break = 1'b1;
        Transmit_Start = 1'b1;
        capture(1, tv, bv, dv);
        Send_Break = 1'b0;
        capture(24, tv2, bv2, dv2);
        Transmit_Start = 1'b0;
        check("break_then_3c", {7'd0, tv[0], tv2[23:0]}, 32'b0000_0000_0000_1_0001_1110_0011);
        check("break_busy", {7'd0, bv[0], bv2[23:0]}, 32'b1111_1111_1111_0_1111_1111_1111);
        idle(3);

        // Reset during data bit 4 of 0xFF aborts at once
        @(negedge Clk);
        Tx_Data = 8'hFF;
        Transmit_Start = 1'b1;
        repeat (5) @(negedge Clk);
        #2 Rst = 1'b1;
        Transmit_Start = 1'b0;
        #1 check("reset_abort", {29'd0, Tx, Tx_Busy, Tx_Done}, 32'b100);
        @(negedge Clk);
        #2 Rst = 1'b0;
        idle(2);

        // Held request: back-to-back 0x55 frames with one idle cycle between
        @(negedge Clk);
        Tx_Data = 8'h55;
        Transmit_Start = 1'b1;
        capture(25, tv, bv, dv);
        Transmit_Start = 1'b0;
        check("b2b_55", tv, 32'b0010_1010_1011_1_0010_1010_1011);
        check("b2b_done", dv, 32'b0000_0000_0001_0_0000_0000_0001);
        idle(3);

        // Randomised traffic, including mid-frame input changes and resets
        repeat (400) begin
            @(negedge Clk);
            Tx_Data        = DB'($urandom);
            Transmit_Start = ($urandom_range(0, 3) != 0);
            Send_Break     = ($urandom_range(0, 9) == 0);
            CTS            = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) begin
                #2 Rst = 1'b1;
                #1 check("rand_reset", {29'd0, Tx, Tx_Busy, Tx_Done}, 32'b100);
                @(negedge Clk);
                #2 Rst = 1'b0;
            end
            repeat ($urandom_range(0, 12)) @(negedge Clk);
        end

        idle(1);
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge Clk);
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
